serial_sub64: RTL and testbench
===============================

SERIAL_SUB64 -- requirements
Module: serial_sub64

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, operand width in bits.
REQ-002 The block SHALL have parameter SLICE, default 4, bits subtracted per cycle; WIDTH SHALL be an integer multiple of SLICE.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1, operands and borrow-in are presented.
REQ-006 The block SHALL have port in_ready, output, 1, block can accept operands.
REQ-007 The block SHALL have port A, input, WIDTH, minuend, unsigned or two's complement.
REQ-008 The block SHALL have port B, input, WIDTH, subtrahend.
REQ-009 The block SHALL have port Bin, input, 1, borrow-in.
REQ-010 The block SHALL have port out_valid, output, 1, result is valid.
REQ-011 The block SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 The block SHALL have port Diff, output, WIDTH, A - B - Bin modulo 2^WIDTH.
REQ-013 The block SHALL have port Bout, output, 1, unsigned borrow-out: 1 iff A < B + Bin.
REQ-014 The block SHALL have port Ovf, output, 1, signed overflow of A - B - Bin.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Accept SHALL occur on a rising edge where state is IDLE and in_valid = 1; A, B and Bin SHALL be registered and the state SHALL become RUN.
REQ-018 In IDLE with in_valid = 0 the state SHALL remain IDLE.
REQ-019 In RUN, each edge SHALL process one slice, LSB slice first: slice bits = A_s - B_s - borrow, with borrow initialised to the captured Bin and updated from each slice's borrow-out.
REQ-020 Per-bit logic SHALL be the full subtractor: d = a ^ b ^ bi; bo = (~a & b) | (~a & bi) | (b & bi).
REQ-021 A slice counter SHALL count 0 to WIDTH/SLICE-1; after the edge processing the last slice the state SHALL become DONE.
REQ-022 out_valid SHALL first be 1 exactly WIDTH/SLICE cycles after the accept edge (16 for the defaults).
REQ-023 On DONE entry Bout SHALL equal the final borrow and Ovf SHALL equal (A[MSB] != B[MSB]) & (Diff[MSB] != A[MSB]).
REQ-024 In DONE, Diff, Bout and Ovf SHALL hold stable while out_ready = 0.
REQ-025 A DONE edge with out_ready = 1 SHALL return the state to IDLE; a new accept is possible no earlier than the following edge.
REQ-026 Changes on A, B, Bin or in_valid outside IDLE SHALL have no effect on the operation in flight.
REQ-027 out_ready SHALL be ignored outside DONE.
REQ-028 Diff, Bout and Ovf SHALL keep the last result in IDLE until the next DONE entry.

Reset
REQ-029 An edge with rst = 1 SHALL force state IDLE, slice counter 0, Diff = 0, Bout = 0, Ovf = 0, out_valid = 0 and in_ready = 1 on the next cycle.
REQ-030 Reset SHALL take priority over all other inputs, including an accept, and SHALL abort RUN or DONE with no result produced.
REQ-031 in_ready SHALL be 1 on the first cycle after rst deasserts.

Verification
REQ-032 Test 1: A=0x10, B=0x01, Bin=0, out_ready=1 -> Diff=0x0F, Bout=0, Ovf=0, out_valid 16 cycles after accept, high for 1 cycle.
REQ-033 Test 2: A=0, B=0, Bin=1 -> Diff=0xFFFF_FFFF_FFFF_FFFF, Bout=1, Ovf=0, proving the borrow ripples across all 16 slices.
REQ-034 Test 3: A=0x8000_0000_0000_0000, B=1, Bin=0 -> Diff=0x7FFF_FFFF_FFFF_FFFF, Bout=0, Ovf=1.
REQ-035 Test 4: out_ready held 0 for 5 cycles in DONE while A and B toggle -> outputs stable, out_valid stays 1; out_ready=1 -> IDLE next cycle.
REQ-036 Test 5: rst pulsed on the 8th cycle of RUN -> out_valid never asserts, Diff=0, in_ready=1 the next cycle; a fresh A=5, B=3 then yields Diff=2.
REQ-037 Test 6: in_valid held 1 with new operands for 1000 random back-to-back transactions -> every result matches a reference A - B - Bin, Bout and Ovf model, with one accept per transaction.

Source files
------------

// File: rtl/serial_sub64.sv
// serial_sub64: multi-cycle subtractor computing Diff = A - B - Bin, SLICE bits per cycle.
// WIDTH must be an integer multiple of SLICE.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid, in_ready   - operand handshake (in_ready high only while idle)
//   A, B, Bin            - minuend, subtrahend, borrow-in
//   out_valid, out_ready - result handshake (out_valid high only while done)
//   Diff, Bout, Ovf      - difference, unsigned borrow-out, signed overflow
module serial_sub64 #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             Ovf
);

   localparam int unsigned NSL = WIDTH / SLICE;
   localparam int unsigned CW  = (NSL > 1) ? $clog2(NSL) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] res_r;
   logic             borrow;
   logic             a_msb;
   logic             b_msb;

   logic [SLICE-1:0]       slice_d;
   logic [SLICE:0]         bc;
   logic [WIDTH+SLICE-1:0] res_cat;
   logic [WIDTH-1:0]       res_next;

   // One slice of ripple full subtractors on the low bits of the shifting operands
   always_comb begin
      bc      = '0;
      slice_d = '0;
      bc[0]   = borrow;
      for (int unsigned i = 0; i < SLICE; i++) begin
         slice_d[i] = a_r[i] ^ b_r[i] ^ bc[i];
         bc[i+1]    = (~a_r[i] & b_r[i]) | (~a_r[i] & bc[i]) | (b_r[i] & bc[i]);
      end
      // New slice enters at the top; after NSL shifts the LSB slice sits at bit 0
      res_cat  = {slice_d, res_r};
      res_next = res_cat[WIDTH+SLICE-1:SLICE];
   end

   // Control FSM and datapath; Diff/Bout/Ovf only update on DONE entry
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         a_r       <= '0;
         b_r       <= '0;
         res_r     <= '0;
         borrow    <= 1'b0;
         a_msb     <= 1'b0;
         b_msb     <= 1'b0;
         Diff      <= '0;
         Bout      <= 1'b0;
         Ovf       <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r      <= A;
                  b_r      <= B;
                  borrow   <= Bin;
                  a_msb    <= A[WIDTH-1];
                  b_msb    <= B[WIDTH-1];
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               a_r    <= a_r >> SLICE;
               b_r    <= b_r >> SLICE;
               res_r  <= res_next;
               borrow <= bc[SLICE];
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(NSL - 1)) begin
                  cnt       <= '0;
                  Diff      <= res_next;
                  Bout      <= bc[SLICE];
                  // Operand signs differ and result sign differs from the minuend
                  Ovf       <= (a_msb ^ b_msb) & (slice_d[SLICE-1] ^ a_msb);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub64.sv
// tb_serial_sub64: directed and random checks of serial_sub64 using a result scoreboard.
module tb_serial_sub64;

   localparam int unsigned W = 64;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          Bin;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  Diff;
   logic          Bout;
   logic          Ovf;

   typedef struct {
      logic [W-1:0] d;
      logic         bo;
      logic         ov;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   accepts = 0;

   serial_sub64 #(.WIDTH(64), .SLICE(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
      .Diff(Diff), .Bout(Bout), .Ovf(Ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (!rst && in_valid && in_ready) accepts++;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: push the expected result for the operands being presented
   task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      exp_t e;
      logic [W:0] wide;
      wide = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
      e.d  = wide[W-1:0];
      e.bo = ({1'b0, a} < ({1'b0, b} + {{W{1'b0}}, bi}));
      e.ov = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
      sb.push_back(e);
   endtask

   task automatic check_result(input string tag, output exp_t e);
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL %s: result observed %h with empty scoreboard", tag, Diff);
         e.d = '0; e.bo = 1'b0; e.ov = 1'b0;
      end else begin
         e = sb.pop_front();
         chk({tag, "_diff"}, Diff, e.d);
         chk({tag, "_bout"}, W'(Bout), W'(e.bo));
         chk({tag, "_ovf"},  W'(Ovf),  W'(e.ov));
      end
   endtask

   // Present operands in IDLE and let the next edge accept them
   task automatic start(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      chk({tag, "_in_ready"}, W'(in_ready), W'(1'b1));
      A = a; B = b; Bin = bi; in_valid = 1'b1;
      push_exp(a, b, bi);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Cycles from the accept edge until out_valid, bounded
   task automatic wait_done(input string tag, output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (!out_valid) begin
         tests++;
         fails++;
         $error("FAIL %s_timeout: out_valid observed 0 expected 1 within 40 cycles", tag);
      end
   endtask

   initial begin
      int   cyc;
      int   k;
      int   vhits;
      exp_t e;
      logic [W-1:0] ra, rb;
      logic         rbi;

      rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Bin = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_in_ready",  W'(in_ready),  W'(1'b1));
      chk("rst_out_valid", W'(out_valid), W'(1'b0));
      chk("rst_diff",      Diff,          '0);
      chk("rst_bout",      W'(Bout),      W'(1'b0));
      chk("rst_ovf",       W'(Ovf),       W'(1'b0));
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_in_ready", W'(in_ready), W'(1'b1));

      // Test 1: simple subtract, latency and single-cycle out_valid
      start("t1", 64'h10, 64'h01, 1'b0);
      chk("t1_run_in_ready", W'(in_ready), W'(1'b0));
      wait_done("t1", cyc);
      chk("t1_latency", W'(cyc), W'(16));
      check_result("t1", e);
      @(posedge clk); #1;
      chk("t1_valid_pulse", W'(out_valid), W'(1'b0));
      chk("t1_idle_ready",  W'(in_ready),  W'(1'b1));

      // Test 2: borrow ripples through every slice
      start("t2", 64'h0, 64'h0, 1'b1);
      wait_done("t2", cyc);
      chk("t2_latency", W'(cyc), W'(16));
      check_result("t2", e);
      chk("t2_diff_const", Diff, 64'hFFFF_FFFF_FFFF_FFFF);
      @(posedge clk); #1;

      // Test 3: signed overflow at the most negative value
      start("t3", 64'h8000_0000_0000_0000, 64'h1, 1'b0);
      wait_done("t3", cyc);
      check_result("t3", e);
      chk("t3_diff_const", Diff, 64'h7FFF_FFFF_FFFF_FFFF);
      chk("t3_ovf_const",  W'(Ovf), W'(1'b1));
      @(posedge clk); #1;

      // Test 4: backpressure in DONE with toggling inputs
      out_ready = 1'b0;
      start("t4", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
      wait_done("t4", cyc);
      check_result("t4", e);
      for (int i = 0; i < 5; i++) begin
         A = ~A; B = ~B; Bin = ~Bin; in_valid = ~in_valid;
         @(posedge clk); #1;
         chk("t4_hold_valid", W'(out_valid), W'(1'b1));
         chk("t4_hold_diff",  Diff,          e.d);
         chk("t4_hold_bout",  W'(Bout),      W'(e.bo));
         chk("t4_hold_ovf",   W'(Ovf),       W'(e.ov));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("t4_idle_valid", W'(out_valid), W'(1'b0));
      chk("t4_idle_ready", W'(in_ready),  W'(1'b1));
      chk("t4_idle_diff",  Diff,          e.d);

      // Test 5: reset during RUN aborts the operation
      A = 64'hDEAD_BEEF_0000_1111; B = 64'h1234; Bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t5_rst_valid", W'(out_valid), W'(1'b0));
      chk("t5_rst_diff",  Diff,          '0);
      chk("t5_rst_ready", W'(in_ready),  W'(1'b1));
      vhits = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (out_valid) vhits++;
      end
      chk("t5_no_result", W'(vhits), '0);
      start("t5b", 64'h5, 64'h3, 1'b0);
      wait_done("t5b", cyc);
      check_result("t5b", e);
      chk("t5b_diff_const", Diff, 64'h2);
      @(posedge clk); #1;

      // Test 6: back-to-back random transactions, inputs churn outside IDLE
      accepts = 0;
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         k = 0;
         while (!in_ready && k < 40) begin
            @(posedge clk); #1;
            k++;
         end
         ra  = {$urandom(), $urandom()};
         rb  = {$urandom(), $urandom()};
         rbi = 1'($urandom());
         if (n % 8 == 0) rb = ra;
         A = ra; B = rb; Bin = rbi;
         push_exp(ra, rb, rbi);
         @(posedge clk); #1;
         k = 0;
         while (!out_valid && k < 40) begin
            A = {$urandom(), $urandom()};
            B = {$urandom(), $urandom()};
            Bin = 1'($urandom());
            @(posedge clk); #1;
            k++;
         end
         if (!out_valid) begin
            tests++;
            fails++;
            $error("FAIL t6_timeout: out_valid observed 0 expected 1 in transaction %0d", n);
         end else begin
            check_result("t6", e);
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("t6_accepts", W'(accepts), W'(1000));
      chk("sb_drained", W'(sb.size()), '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
